// File: rtl/plab4_net_router_pkg.sv
// Shared types and helpers for the router output-port allocator.
// Holds the allocator FSM encoding and the select-width helper.
package plab4_net_router_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Width of a binary index over n inputs; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/plab4_net_router_prio_pick.sv
// Variable-priority picker: one-hot grant to the first requester at or
// after i_prio_ptr, wrapping modulo p_num_reqs.
module plab4_net_router_prio_pick
    import plab4_net_router_pkg::*;
#(
    parameter int p_num_reqs = 3,
    parameter int p_sel_w    = sel_width(p_num_reqs)
) (
    input  logic [p_num_reqs-1:0] i_reqs,
    input  logic [p_sel_w-1:0]    i_prio_ptr,
    output logic [p_num_reqs-1:0] o_grant
);

    logic [p_sel_w:0]   w_sum;
    logic [p_sel_w-1:0] w_idx;
    logic               w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            // Walk candidates in priority order starting from the pointer.
            w_sum = {1'b0, i_prio_ptr} + (p_sel_w + 1)'(i);
            if (w_sum >= (p_sel_w + 1)'(p_num_reqs)) begin
                w_sum = w_sum - (p_sel_w + 1)'(p_num_reqs);
            end
            w_idx = w_sum[p_sel_w-1:0];
            if (!w_found && i_reqs[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/plab4_net_router_output_alloc.sv
// Output-port allocator: packet-locking round-robin arbitration gated by
// a downstream credit counter, with zero-cycle grant latency.
module plab4_net_router_output_alloc
    import plab4_net_router_pkg::*;
#(
    parameter int p_num_reqs    = 3,
    parameter int p_num_credits = 4,
    localparam int c_sel_w      = sel_width(p_num_reqs)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [p_num_reqs-1:0] reqs,
    input  logic [p_num_reqs-1:0] tails,
    output logic [p_num_reqs-1:0] grants,
    output logic                  out_val,
    output logic [c_sel_w-1:0]    xbar_sel,
    input  logic                  credit_return,
    output logic                  credit_err,
    output state_t                dbg_state
);

    localparam int                 c_cred_w   = $clog2(p_num_credits + 1);
    localparam logic [c_cred_w-1:0] c_cred_max = c_cred_w'(p_num_credits);
    localparam logic [c_sel_w-1:0]  c_last_idx = c_sel_w'(p_num_reqs - 1);

    // Handshake: a flit at input i moves when reqs[i] and grants[i] are
    // both high in the same cycle; grants never depend on a later cycle.

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_sel_w-1:0]    r_prio_ptr;
    logic [c_sel_w-1:0]    w_ptr_nxt;
    logic [c_sel_w-1:0]    r_lock_idx;
    logic [c_sel_w-1:0]    w_lock_nxt;
    logic [c_cred_w-1:0]   r_credits;
    logic                  r_credit_err;

    logic [p_num_reqs-1:0] w_pick;
    logic [p_num_reqs-1:0] w_lock_oh;
    logic [p_num_reqs-1:0] w_grants;
    logic [c_sel_w-1:0]    w_sel;
    logic [c_sel_w-1:0]    w_ptr_after;
    logic                  w_out_val;

    plab4_net_router_prio_pick #(
        .p_num_reqs (p_num_reqs),
        .p_sel_w    (c_sel_w)
    ) u_prio_pick (
        .i_reqs     (reqs),
        .i_prio_ptr (r_prio_ptr),
        .o_grant    (w_pick)
    );

    always_comb begin
        w_lock_oh             = '0;
        w_lock_oh[r_lock_idx] = 1'b1;
        w_grants              = '0;
        // Outputs stay quiet while reset is held, even with live requests.
        if (reset && (r_credits != '0)) begin
            if (r_state == ST_IDLE) begin
                w_grants = w_pick;
            end else if (reqs[r_lock_idx]) begin
                w_grants = w_lock_oh;
            end
        end
        w_out_val = |w_grants;
        w_sel     = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (w_grants[i]) begin
                w_sel = c_sel_w'(i);
            end
        end
        w_ptr_after = (w_sel == c_last_idx) ? '0 : w_sel + 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_prio_ptr;
        w_lock_nxt  = r_lock_idx;
        if (w_out_val) begin
            case (r_state)
                ST_IDLE: begin
                    if (tails[w_sel]) begin
                        w_ptr_nxt = w_ptr_after;
                    end else begin
                        w_state_nxt = ST_LOCKED;
                        w_lock_nxt  = w_sel;
                    end
                end
                ST_LOCKED: begin
                    if (tails[w_sel]) begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = w_ptr_after;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_prio_ptr <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio_ptr <= w_ptr_nxt;
            r_lock_idx <= w_lock_nxt;
        end
    end

    // Send and return in the same cycle cancel; a lone return at full is an error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credits    <= c_cred_max;
            r_credit_err <= 1'b0;
        end else begin
            case ({w_out_val, credit_return})
                2'b10: r_credits <= r_credits - 1'b1;
                2'b01: begin
                    if (r_credits == c_cred_max) begin
                        r_credit_err <= 1'b1;
                    end else begin
                        r_credits <= r_credits + 1'b1;
                    end
                end
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign grants     = w_grants;
    assign out_val    = w_out_val;
    assign xbar_sel   = w_sel;
    assign credit_err = r_credit_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_plab4_net_router_output_alloc.sv
// Bench for the output allocator: one instance with default credits and
// one with two credits, checked through an expected-result queue.
module tb_plab4_net_router_output_alloc;

    import plab4_net_router_pkg::*;

    logic       clk;
    logic       reset;

    logic [2:0] a_reqs, a_tails, a_grants;
    logic       a_cr, a_out_val, a_err;
    logic [1:0] a_sel;
    state_t     a_state;

    logic [2:0] b_reqs, b_tails, b_grants;
    logic       b_cr, b_out_val, b_err;
    logic [1:0] b_sel;
    state_t     b_state;

    int         n_checks;
    int         n_errors;
    logic [6:0] exp_q[$];

    plab4_net_router_output_alloc #(
        .p_num_reqs    (3),
        .p_num_credits (4)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .reqs          (a_reqs),
        .tails         (a_tails),
        .grants        (a_grants),
        .out_val       (a_out_val),
        .xbar_sel      (a_sel),
        .credit_return (a_cr),
        .credit_err    (a_err),
        .dbg_state     (a_state)
    );

    plab4_net_router_output_alloc #(
        .p_num_reqs    (3),
        .p_num_credits (2)
    ) u_dut_c2 (
        .clk           (clk),
        .reset         (reset),
        .reqs          (b_reqs),
        .tails         (b_tails),
        .grants        (b_grants),
        .out_val       (b_out_val),
        .xbar_sel      (b_sel),
        .credit_return (b_cr),
        .credit_err    (b_err),
        .dbg_state     (b_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] enc(input logic [2:0] g);
        logic [1:0] s;
        s = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (g[i]) s = 2'(i);
        end
        return s;
    endfunction

    // Driver: apply one cycle of stimulus, push its expected outputs,
    // then compare at the falling edge before state advances.
    task automatic step(input bit use_b, input logic rst, input logic [2:0] rq,
                        input logic [2:0] tl, input logic cr,
                        input logic [2:0] eg, input logic ee, input string tag);
        logic [6:0] got;
        reset = rst;
        if (use_b) begin
            b_reqs = rq; b_tails = tl; b_cr = cr;
            a_reqs = '0; a_tails = '0; a_cr = 1'b0;
        end else begin
            a_reqs = rq; a_tails = tl; a_cr = cr;
            b_reqs = '0; b_tails = '0; b_cr = 1'b0;
        end
        exp_q.push_back({ee, eg, |eg, enc(eg)});
        @(negedge clk);
        got = use_b ? {b_err, b_grants, b_out_val, b_sel}
                    : {a_err, a_grants, a_out_val, a_sel};
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            check(tag, 32'(got), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        a_reqs = '0; a_tails = '0; a_cr = 1'b0;
        b_reqs = '0; b_tails = '0; b_cr = 1'b0;
        @(posedge clk);
        #1;

        // Outputs held low during reset despite requests
        step(0, 0, 3'b111, 3'b111, 0, 3'b000, 0, "rst_hold0");
        step(0, 0, 3'b111, 3'b111, 0, 3'b000, 0, "rst_hold1");

        // Round robin over single-flit packets
        step(0, 1, 3'b111, 3'b111, 1, 3'b001, 0, "rr_0");
        step(0, 1, 3'b111, 3'b111, 1, 3'b010, 0, "rr_1");
        step(0, 1, 3'b111, 3'b111, 1, 3'b100, 0, "rr_2");

        // Three-flit packet on input 1 holds the output
        step(0, 1, 3'b001, 3'b111, 1, 3'b001, 0, "pre_pkt");
        step(0, 1, 3'b111, 3'b101, 1, 3'b010, 0, "pkt_head");
        step(0, 1, 3'b111, 3'b101, 1, 3'b010, 0, "pkt_body");
        step(0, 1, 3'b111, 3'b111, 1, 3'b010, 0, "pkt_tail");
        step(0, 1, 3'b111, 3'b111, 1, 3'b100, 0, "pkt_next");

        // Lock on input 0 bubbles while its request drops
        step(0, 1, 3'b001, 3'b000, 1, 3'b001, 0, "lock0_head");
        step(0, 1, 3'b110, 3'b000, 0, 3'b000, 0, "lock0_bub0");
        step(0, 1, 3'b110, 3'b000, 0, 3'b000, 0, "lock0_bub1");
        step(0, 1, 3'b111, 3'b001, 1, 3'b001, 0, "lock0_tail");

        // Credit count still full after paired send/return: four sends then stall
        step(0, 1, 3'b111, 3'b111, 0, 3'b010, 0, "cred_s0");
        step(0, 1, 3'b111, 3'b111, 0, 3'b100, 0, "cred_s1");
        step(0, 1, 3'b111, 3'b111, 0, 3'b001, 0, "cred_s2");
        step(0, 1, 3'b111, 3'b111, 0, 3'b010, 0, "cred_s3");
        step(0, 1, 3'b111, 3'b111, 0, 3'b000, 0, "cred_empty");
        step(0, 1, 3'b111, 3'b111, 1, 3'b000, 0, "cred_ret");
        step(0, 1, 3'b111, 3'b111, 0, 3'b100, 0, "cred_one");
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 3'b000, 3'b000, 1, 3'b000, 0, "cred_refill");
        end

        // Send plus return at full is harmless; lone return at full is sticky error
        step(0, 1, 3'b001, 3'b111, 1, 3'b001, 0, "full_pair");
        step(0, 1, 3'b000, 3'b000, 1, 3'b000, 0, "full_ret");
        step(0, 1, 3'b000, 3'b000, 0, 3'b000, 1, "err_set");
        step(0, 1, 3'b000, 3'b000, 0, 3'b000, 1, "err_hold");

        // Reset mid-packet on input 2 abandons the lock
        step(0, 1, 3'b100, 3'b000, 1, 3'b100, 1, "lock2_head");
        step(0, 1, 3'b100, 3'b000, 1, 3'b100, 1, "lock2_body");
        step(0, 0, 3'b111, 3'b111, 0, 3'b000, 0, "mid_rst");
        step(0, 1, 3'b111, 3'b111, 1, 3'b001, 0, "post_rst");

        // Two-credit instance: stall until a credit comes back
        step(1, 1, 3'b001, 3'b001, 0, 3'b001, 0, "c2_send0");
        step(1, 1, 3'b001, 3'b001, 0, 3'b001, 0, "c2_send1");
        step(1, 1, 3'b001, 3'b001, 0, 3'b000, 0, "c2_stall0");
        step(1, 1, 3'b001, 3'b001, 0, 3'b000, 0, "c2_stall1");
        step(1, 1, 3'b001, 3'b001, 1, 3'b000, 0, "c2_ret");
        step(1, 1, 3'b001, 3'b001, 0, 3'b001, 0, "c2_resend");
        step(1, 1, 3'b001, 3'b001, 0, 3'b000, 0, "c2_stall2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/plab4_net_router_output_alloc.md
PLAB4_NET_ROUTER_OUTPUT_ALLOC -- requirements
Module: plab4_net_router_output_alloc

Interface
REQ-001 SHALL have parameter p_num_reqs, default 3, number of input ports competing for this output (legal range 2..8).
REQ-002 SHALL have parameter p_num_credits, default 4, downstream buffer depth in flits (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port reqs  input  p_num_reqs  bit i: input i holds a flit routed to this output.
REQ-006 SHALL have port tails  input  p_num_reqs  bit i: the flit at input i is a packet tail; single-flit packets assert both head and tail.
REQ-007 SHALL have port grants  output  p_num_reqs  one-hot or zero; bit i: input i's flit transfers this cycle.
REQ-008 SHALL have port out_val  output  1  a flit leaves on the output this cycle.
REQ-009 SHALL have port xbar_sel  output  clog2(p_num_reqs)  crossbar select for this output.
REQ-010 SHALL have port credit_return  input  1  downstream freed one buffer slot this cycle.
REQ-011 SHALL have port credit_err  output  1  sticky: a credit_return arrived while the counter was already full.

Function
REQ-012 SHALL implement a two-state FSM with states IDLE (no packet owns the output) and LOCKED (input lock_idx owns it until its tail transfers).
REQ-013 SHALL make grants, out_val and xbar_sel combinational from current state, reqs, tails and credit count: zero-cycle grant latency.
REQ-014 SHALL issue no grant when credit count is 0, regardless of state.
REQ-015 IDLE with credits>0 and reqs nonzero: SHALL grant the first requester at or after prio_ptr, wrapping modulo p_num_reqs.
REQ-016 IDLE grant of input g with tails[g]=0: SHALL move to LOCKED with lock_idx=g.
REQ-017 IDLE grant of input g with tails[g]=1: SHALL stay IDLE and set prio_ptr=(g+1) mod p_num_reqs.
REQ-018 LOCKED: SHALL grant only lock_idx when reqs[lock_idx]=1 and credits>0; other requests are ignored and the output idles (bubble) otherwise.
REQ-019 LOCKED grant with tails[lock_idx]=1: SHALL return to IDLE and set prio_ptr=(lock_idx+1) mod p_num_reqs.
REQ-020 SHALL leave prio_ptr unchanged on non-tail transfers and on idle cycles.
REQ-021 SHALL set out_val = OR of grants.
REQ-022 SHALL set xbar_sel to the binary index of the granted input, and to 0 when no grant.
REQ-023 Credit counter: SHALL decrement by 1 on out_val, increment by 1 on credit_return, and remain unchanged when both occur together.
REQ-024 Credit counter: SHALL saturate at p_num_credits; a credit_return at full with no simultaneous send SHALL set credit_err, which holds until reset.
REQ-025 Credit counter SHALL NOT underflow; this follows from REQ-014.

Reset
REQ-026 On reset low, SHALL asynchronously force state=IDLE, prio_ptr=0, lock_idx=0, credits=p_num_credits and credit_err=0.
REQ-027 While reset is low, grants, out_val and xbar_sel SHALL be 0.
REQ-028 Reset asserted mid-packet SHALL abandon the lock; the first cycle after release behaves as a fresh IDLE.
REQ-029 Reset release SHALL be synchronised externally; the block needs no internal synchroniser.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE=0, LOCKED=1) and a sel-width helper function in shared package plab4_net_router_pkg.
REQ-031 SHALL factor the combinational variable-priority pick (reqs, prio_ptr -> one-hot) into sub-module plab4_net_router_prio_pick; the FSM, credit counter and pointers stay in this module.

Verification
REQ-032 The bench SHALL check: reset with N=3; reqs=111, all tails=1 for 3 cycles -> grants 001,010,100; xbar_sel 0,1,2.
REQ-033 The bench SHALL check: 3-flit packet on input 1 (tails 0,0,1) with reqs=111 throughout -> grants=010 for 3 consecutive cycles, then 100.
REQ-034 The bench SHALL check: p_num_credits=2, no credit_return, reqs=001, tails=1 -> two grants, then out_val=0 until credit_return pulses, then one grant the next cycle.
REQ-035 The bench SHALL check: LOCKED on input 0 with reqs[0] dropped for 2 cycles while reqs=110 -> grants=000 both cycles; resumes 001 when reqs[0] returns.
REQ-036 The bench SHALL check: credit_return at full credits -> credit_err=1 next cycle and remains 1; a simultaneous send plus return at full -> no error, count unchanged.
REQ-037 The bench SHALL check: reset asserted mid-packet on input 2 -> outputs 0 immediately; after release, reqs=111 with tails=1 -> grant 001.
